// File: rtl/output_ni_ser.sv
`default_nettype none
// ============================================================================
//  Module   : output_ni_ser
//  Function : Output network-interface serializer. Accepts one granted flit
//             (one VN slice of the candidate inputs), breaks it into phits
//             sent LSB first, and tracks per-VC downstream credits.
//  Revision : 1.0  initial release
// ============================================================================
module output_ni_ser #(
  parameter int ID             = 0,
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int PHIT_SIZE      = 16,
  parameter int NUM_VC         = 2,
  parameter int NUM_VN         = 3,
  parameter int BROADCAST_SIZE = 5,
  parameter int CREDITS        = 2,
  localparam int NUM_PHITS     = FLIT_SIZE / PHIT_SIZE,
  localparam int NUM_VN_X_VC   = NUM_VN * NUM_VC,
  localparam int BITS_VN_X_VC  = (NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1,
  localparam int CW            = $clog2(CREDITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst_p,
  input  logic [NUM_VN*FLIT_SIZE-1:0]        Pre_Flit,
  input  logic [NUM_VN*FLIT_TYPE_SIZE-1:0]   Pre_FlitType,
  input  logic [NUM_VN*BROADCAST_SIZE-1:0]   Pre_BroadcastFlit,
  input  logic [NUM_VN_X_VC-1:0]             GRANTS,
  input  logic [BITS_VN_X_VC-1:0]            vc_selected,
  input  logic                               credit_in,
  input  logic [BITS_VN_X_VC-1:0]            credit_vc,
  output logic                               ready,
  output logic [NUM_VN_X_VC-1:0]             credit_avail,
  output logic                               free_VC,
  output logic [BITS_VN_X_VC-1:0]            vc_to_release,
  output logic [PHIT_SIZE-1:0]               PhitOut,
  output logic                               PhitLast,
  output logic [FLIT_TYPE_SIZE-1:0]          FlitTypeOut,
  output logic [BROADCAST_SIZE-1:0]          BroadcastFlitOut,
  output logic [BITS_VN_X_VC-1:0]            VC_out,
  output logic                               Valid
);

  localparam int PW = (NUM_PHITS > 1) ? $clog2(NUM_PHITS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Flit type codes that end a packet and therefore release the VC
  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_TAIL        = FLIT_TYPE_SIZE'(2);
  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER_TAIL = FLIT_TYPE_SIZE'(3);

  // ID identifies the node but does not alter serializer behaviour
  if (ID < 0) begin : g_id_range
  end

  logic [0:0]                state_q, state_d;
  logic [PW-1:0]             phit_q, phit_d;
  logic [FLIT_SIZE-1:0]      flit_q;
  logic [FLIT_TYPE_SIZE-1:0] type_q;
  logic [BROADCAST_SIZE-1:0] bc_q;
  logic [BITS_VN_X_VC-1:0]   vc_q;
  logic [CW-1:0]             credit_q [NUM_VN_X_VC];

  logic [FLIT_SIZE-1:0]      sel_flit;
  logic [FLIT_TYPE_SIZE-1:0] sel_type;
  logic [BROADCAST_SIZE-1:0] sel_bc;
  logic                      vc_has_credit;
  logic                      last_phit;
  logic                      accept;
  logic [PHIT_SIZE-1:0]      phits [NUM_PHITS];

  // Route the VN slice addressed by the one-hot grant (VN = index / NUM_VC)
  always_comb begin
    sel_flit = '0;
    sel_type = '0;
    sel_bc   = '0;
    for (int g = 0; g < NUM_VN_X_VC; g++) begin
      if (GRANTS[g]) begin
        sel_flit = Pre_Flit[(g / NUM_VC) * FLIT_SIZE +: FLIT_SIZE];
        sel_type = Pre_FlitType[(g / NUM_VC) * FLIT_TYPE_SIZE +: FLIT_TYPE_SIZE];
        sel_bc   = Pre_BroadcastFlit[(g / NUM_VC) * BROADCAST_SIZE +: BROADCAST_SIZE];
      end
    end
  end

  // Credit lookup for the selected VC; out-of-range VC numbers never have credit
  always_comb begin
    vc_has_credit = 1'b0;
    for (int v = 0; v < NUM_VN_X_VC; v++) begin
      if (vc_selected == BITS_VN_X_VC'(v)) vc_has_credit = (credit_q[v] != '0);
    end
  end

  assign last_phit     = (phit_q == PW'(NUM_PHITS - 1));
  assign ready         = (state_q == S_IDLE) || last_phit;
  assign accept        = (GRANTS != '0) && ready && vc_has_credit;
  assign free_VC       = accept && ((sel_type == TYPE_TAIL) || (sel_type == TYPE_HEADER_TAIL));
  assign vc_to_release = vc_selected;

  // Next-state: a new flit always restarts at phit 0, even on the last phit of the previous one
  always_comb begin
    state_d = state_q;
    phit_d  = phit_q;
    if (accept) begin
      state_d = S_SEND;
      phit_d  = '0;
    end else if (state_q == S_SEND) begin
      if (last_phit) begin
        state_d = S_IDLE;
        phit_d  = '0;
      end else begin
        phit_d = phit_q + PW'(1);
      end
    end
  end

  // FSM state and phit counter
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= S_IDLE;
      phit_q  <= '0;
    end else begin
      state_q <= state_d;
      phit_q  <= phit_d;
    end
  end

  // Holding register loaded on every accepted grant
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      flit_q <= '0;
      type_q <= '0;
      bc_q   <= '0;
      vc_q   <= '0;
    end else if (accept) begin
      flit_q <= sel_flit;
      type_q <= sel_type;
      bc_q   <= sel_bc;
      vc_q   <= vc_selected;
    end
  end

  // Per-VC credit counters: simultaneous consume and return cancel out
  for (genvar v = 0; v < NUM_VN_X_VC; v++) begin : g_credit
    logic inc;
    logic dec;
    assign inc = credit_in && (credit_vc == BITS_VN_X_VC'(v));
    assign dec = accept && (vc_selected == BITS_VN_X_VC'(v));

    // Saturating increment on return, decrement on accept
    always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
        credit_q[v] <= CW'(CREDITS);
      end else if (inc && !dec && (credit_q[v] != CW'(CREDITS))) begin
        credit_q[v] <= credit_q[v] + CW'(1);
      end else if (dec && !inc) begin
        credit_q[v] <= credit_q[v] - CW'(1);
      end
    end

    assign credit_avail[v] = (credit_q[v] != '0);
  end

  // Split the held flit into phits, phit 0 being the least significant slice
  for (genvar k = 0; k < NUM_PHITS; k++) begin : g_phit
    assign phits[k] = flit_q[k*PHIT_SIZE +: PHIT_SIZE];
  end

  assign Valid            = (state_q == S_SEND);
  assign PhitOut          = Valid ? phits[phit_q] : '0;
  assign PhitLast         = Valid && last_phit;
  assign FlitTypeOut      = Valid ? type_q : '0;
  assign BroadcastFlitOut = Valid ? bc_q   : '0;
  assign VC_out           = Valid ? vc_q   : '0;

endmodule
`default_nettype wire

// File: doc/output_ni_ser.md
OUTPUT_NI_SER -- requirements
Module: output_ni_ser

Interface
REQ-001 SHALL have parameters (name, default, meaning): ID 0 node id; FLIT_SIZE 64 flit bits; FLIT_TYPE_SIZE 2 type bits; PHIT_SIZE 16 link bits (FLIT_SIZE multiple of PHIT_SIZE); NUM_VC 2 VCs per VN; NUM_VN 3 VNs; BROADCAST_SIZE 5 broadcast bits; CREDITS 2 downstream buffer slots per VC.
REQ-002 SHALL derive NUM_PHITS=FLIT_SIZE/PHIT_SIZE, NUM_VN_X_VC=NUM_VN*NUM_VC, bits_VN_X_VC=clog2(NUM_VN_X_VC), CW=clog2(CREDITS+1).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_p  in  1  one clock; reset asynchronous, active-high
- Pre_Flit  in  NUM_VN*FLIT_SIZE  candidate flit per VN
- Pre_FlitType  in  NUM_VN*FLIT_TYPE_SIZE  type per VN
- Pre_BroadcastFlit  in  NUM_VN*BROADCAST_SIZE  broadcast field per VN
- GRANTS  in  NUM_VN_X_VC  one-hot grant, VN=index/NUM_VC
- vc_selected  in  bits_VN_X_VC  VC carrying granted flit
- credit_in  in  1  downstream returns one credit
- credit_vc  in  bits_VN_X_VC  VC of returned credit
- ready  out  1  grant can be accepted this cycle
- credit_avail  out  NUM_VN_X_VC  bit v = credit count of VC v nonzero
- free_VC  out  1  accepted flit is tail/header_tail
- vc_to_release  out  bits_VN_X_VC  VC released
- PhitOut  out  PHIT_SIZE  link phit
- PhitLast  out  1  last phit of flit
- FlitTypeOut  out  FLIT_TYPE_SIZE  type of flit on link
- BroadcastFlitOut  out  BROADCAST_SIZE  broadcast field on link
- VC_out  out  bits_VN_X_VC  VC of flit on link
- Valid  out  1  PhitOut valid

Function
REQ-004 SHALL accept a flit in cycle t iff GRANTS!=0 and ready=1 and credit_avail[vc_selected]=1; otherwise the grant SHALL be ignored, no state change.
REQ-005 SHALL on accept capture slice VN of Pre_Flit, Pre_FlitType, Pre_BroadcastFlit and vc_selected into a holding register.
REQ-006 SHALL drive free_VC combinationally =1 in the accept cycle iff captured type is tail or header_tail; vc_to_release SHALL equal vc_selected at all times.
REQ-007 SHALL implement FSM IDLE/SEND: IDLE->SEND on accept; SEND->IDLE on last phit without accept; SEND->SEND on last phit with accept.
REQ-008 SHALL set ready=1 in IDLE and in SEND when phit counter=NUM_PHITS-1, else 0 (combinational from state).
REQ-009 SHALL emit phit k (k=0..NUM_PHITS-1) as Flit[k*PHIT_SIZE +: PHIT_SIZE], LSB first, one per cycle, first phit registered at t+1.
REQ-010 SHALL hold FlitTypeOut, BroadcastFlitOut, VC_out constant for all phits; PhitLast=1 only on phit NUM_PHITS-1.
REQ-011 SHALL, when no phit is sent, drive Valid=0 and PhitOut, PhitLast, FlitTypeOut, BroadcastFlitOut, VC_out all zero.
REQ-012 SHALL sustain back-to-back flits with no idle cycle between them; NUM_PHITS=1 SHALL yield one flit per cycle.
REQ-013 SHALL keep one CW-bit credit counter per VC; accept decrements counter of vc_selected; credit_in increments counter of credit_vc.
REQ-014 SHALL leave a counter unchanged when accept and credit_in hit the same VC in one cycle.
REQ-015 SHALL saturate increments at CREDITS (extra credit ignored); decrement at 0 cannot occur per REQ-004.

Reset
REQ-016 SHALL, on rst_p=1 asynchronously: FSM IDLE, phit counter 0, all outputs zero except ready=1, all credit counters CREDITS, credit_avail all ones.
REQ-017 SHALL discard an in-flight flit on reset mid-transmission; no further phits of it after reset deasserts.

Verification (NUM_VN=3, NUM_VC=2, FLIT_SIZE=64, PHIT_SIZE=16, CREDITS=2)
REQ-018 Single flit: GRANTS=6'b000100, vc_selected=2, Pre_Flit VN1=64'h4444_3333_2222_1111, type header -> cycles t+1..t+4 PhitOut 1111,2222,3333,4444, VC_out=2, PhitLast only at t+4, free_VC=0.
REQ-019 Back-to-back: second grant at ready in last-phit cycle -> 8 consecutive Valid cycles, no gap; tail second flit -> free_VC=1 in its accept cycle.
REQ-020 Credit exhaustion: two flits on VC 0, no credit_in -> credit_avail[0]=0; third grant ignored, Valid stays 0 after second flit; credit_in on VC 0 -> credit_avail[0]=1, next grant accepted.
REQ-021 Simultaneous: accept on VC 3 with credit_in credit_vc=3 same cycle -> counter stays 2; credit_in on full VC 5 -> stays 2.
REQ-022 Reset mid-flit: rst_p pulsed after phit 1 -> outputs zero immediately, no phits 2-3, ready=1, all counters 2.
REQ-023 Busy grant: GRANTS!=0 while ready=0 -> ignored, free_VC=0, counters unchanged.
